// File: rtl/pwm_dac.sv
// pwm_dac: CPU-loaded sample FIFO feeding an 8-bit PWM generator.
// Each PWM period is 256 phase steps, and each phase step lasts P+1 clocks.
// At every period boundary the next duty value is popped from the FIFO.
// An external RC filter on pwm_out turns the pulse train into an analog level.
//
// Register map, selected by sel (taken from address[3:2]):
//   0 DATA   : a write pushes writeData[7:0]; a read returns 0
//   1 CTRL   : bit0 enable, bits[15:8] prescale P
//   2 STATUS : bit0 empty, bit1 full, bit2 underrun, bit3 overflow, bits[15:8] count
//              writing 1 to bit2 clears underrun; writing 1 to bit3 clears overflow
//   3 CUR    : the active duty value in bits[7:0]
module pwm_dac #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        pwm_out,
  output logic        fifo_low
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] LOW_COUNT  = (AW+1)'(DEPTH / 4);

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_CTRL   = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_CUR    = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic       enable;
  logic [7:0] prescale;
  logic [7:0] pre_cnt;
  logic [7:0] phase;
  logic [7:0] duty;
  logic       underrun;
  logic       overflow;

  logic empty;
  logic full;
  logic tick;
  logic boundary;
  logic push_req;
  logic push_ok;
  logic pop;
  logic underrun_set;
  logic overflow_set;
  logic unused_write_bits;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign fifo_low = (count <= LOW_COUNT);

  // The tick is the last prescale cycle. If the counter is already past a
  // newly written P, it never equals P, so it runs on to its 8-bit wrap
  // without producing a tick.
  assign tick     = enable && (pre_cnt == prescale);
  assign boundary = tick && (phase == 8'hFF);

  // A boundary pop on an empty FIFO is skipped. A push in the same cycle as
  // that boundary counts as a delivered sample, so no underrun is flagged.
  // A push into a full FIFO is accepted only when a pop frees a slot in the
  // same cycle.
  assign push_req     = we && (sel == SEL_DATA);
  assign pop          = boundary && !empty;
  assign push_ok      = push_req && (!full || pop);
  assign underrun_set = boundary && empty && !push_req;
  assign overflow_set = push_req && full && !pop;

  assign unused_write_bits = ^writeData[31:16];

  // Register read mux (combinational)
  always_comb begin
    readData = '0;
    case (sel)
      SEL_DATA:   readData = '0;
      SEL_CTRL:   readData = {16'b0, prescale, 7'b0, enable};
      SEL_STATUS: readData = {16'b0, 8'(count), 4'b0, overflow, underrun, full, empty};
      SEL_CUR:    readData = {24'b0, duty};
      default:    readData = '0;
    endcase
  end

  // Sample storage (no reset needed, since occupancy is tracked by count)
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= writeData[7:0];
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control register and sticky status flags; a new event wins over a clear
  // in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      prescale <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (we && sel == SEL_CTRL) begin
        enable   <= writeData[0];
        prescale <= writeData[15:8];
      end
      if (underrun_set) underrun <= 1'b1;
      else if (we && sel == SEL_STATUS && writeData[2]) underrun <= 1'b0;
      if (overflow_set) overflow <= 1'b1;
      else if (we && sel == SEL_STATUS && writeData[3]) overflow <= 1'b0;
    end
  end

  // Prescale and phase counters, held at zero while disabled so that
  // re-enabling always starts a fresh period
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pre_cnt <= '0;
      phase   <= '0;
    end else begin
      pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (tick) phase <= phase + 8'd1;
    end
  end

  // Active duty, reloaded from the FIFO head at each period boundary
  always_ff @(posedge clk) begin
    if (reset)    duty <= '0;
    else if (pop) duty <= mem[rd_ptr];
  end

  // Registered PWM comparator
  always_ff @(posedge clk) begin
    if (reset) pwm_out <= 1'b0;
    else       pwm_out <= enable && (phase < duty);
  end

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: register-access vectors from a table, followed by directed
// multi-cycle sequences for PWM timing, FIFO overflow/underrun and reset.
module tb_pwm_dac;

  logic        clk;
  logic        reset;
  logic        we;
  logic [1:0]  sel;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        pwm_out;
  logic        fifo_low;

  int checks;
  int errors;

  pwm_dac #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .we(we), .sel(sel), .writeData(writeData),
    .readData(readData), .pwm_out(pwm_out), .fifo_low(fifo_low)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  wsel;
    logic [31:0] wdata;
    logic [1:0]  rsel;
    logic [31:0] exp_rd;
    logic        exp_low;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    we = 1'b1;
    sel = s;
    writeData = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] s, output logic [31:0] d);
    sel = s;
    #1;
    d = readData;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we = 1'b0;
    tick_n(2);
    reset = 1'b0;
  endtask

  // Counts clock edges until CUR shows the expected duty, up to a bound
  task automatic wait_cur(input logic [7:0] exp, input int max, output int n);
    n = 0;
    sel = 2'd3;
    #1;
    while (readData[7:0] !== exp && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pwm_out) h++;
    end
  endtask

  logic [31:0] rdv;
  int          n;
  int          h;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    we = 1'b0;
    sel = 2'd0;
    writeData = '0;

    vecs[0]  = '{"rst_status", 1'b0, 2'd0, 32'h0,         2'd2, 32'h0000_0001, 1'b1};
    vecs[1]  = '{"rst_ctrl",   1'b0, 2'd0, 32'h0,         2'd1, 32'h0000_0000, 1'b1};
    vecs[2]  = '{"rst_cur",    1'b0, 2'd0, 32'h0,         2'd3, 32'h0000_0000, 1'b1};
    vecs[3]  = '{"data_read",  1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_0000, 1'b1};
    vecs[4]  = '{"ctrl_p_ab",  1'b1, 2'd1, 32'hFFFF_AB00, 2'd1, 32'h0000_AB00, 1'b1};
    vecs[5]  = '{"ctrl_clear", 1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b1};
    vecs[6]  = '{"push1",      1'b1, 2'd0, 32'h1234_5655, 2'd2, 32'h0000_0100, 1'b1};
    vecs[7]  = '{"push2",      1'b1, 2'd0, 32'h0000_0077, 2'd2, 32'h0000_0200, 1'b1};
    vecs[8]  = '{"push3",      1'b1, 2'd0, 32'h0000_0011, 2'd2, 32'h0000_0300, 1'b0};
    vecs[9]  = '{"status_wr",  1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_0300, 1'b0};
    vecs[10] = '{"data_rd2",   1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_0000, 1'b0};
    vecs[11] = '{"cur_nopop",  1'b0, 2'd0, 32'h0,         2'd3, 32'h0000_0000, 1'b0};

    do_reset();

    // register access table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) wr(vecs[i].wsel, vecs[i].wdata);
      rd(vecs[i].rsel, rdv);
      check(vecs[i].name, rdv, vecs[i].exp_rd);
      check({vecs[i].name, "_low"}, {31'b0, fifo_low}, {31'b0, vecs[i].exp_low});
    end

    // P=0, duty 0x40: first pop after one 256-cycle period, then 64/256 high
    do_reset();
    wr(2'd0, 32'h40);
    wr(2'd1, 32'h0000_0001);
    wait_cur(8'h40, 2000, n);
    check("p0_first_pop_cycles", n, 256);
    count_high(256, h);
    check("p0_high_count", h, 64);
    tick_n(2);
    rd(2'd2, rdv);
    check("p0_underrun", rdv, 32'h0000_0005);
    rd(2'd3, rdv);
    check("p0_duty_held", rdv, 32'h0000_0040);
    wr(2'd2, 32'h0000_0004);
    rd(2'd2, rdv);
    check("underrun_clear", rdv, 32'h0000_0001);

    // P=3, duty 0x80: 1024-cycle period, 512 high
    do_reset();
    wr(2'd0, 32'h80);
    wr(2'd1, 32'h0000_0301);
    wait_cur(8'h80, 4000, n);
    check("p3_first_pop_cycles", n, 1024);
    count_high(1024, h);
    check("p3_high_count", h, 512);

    // overflow with 9 pushes, then a push on a full FIFO at a pop boundary
    do_reset();
    for (int v = 1; v <= 9; v++) wr(2'd0, 32'(v));
    rd(2'd2, rdv);
    check("ovf_status", rdv, 32'h0000_080A);
    check("ovf_low", {31'b0, fifo_low}, 32'h0);
    wr(2'd2, 32'h0000_0008);
    rd(2'd2, rdv);
    check("ovf_clear", rdv, 32'h0000_0802);
    wr(2'd1, 32'h0000_0001);
    tick_n(255);
    wr(2'd0, 32'h0000_00AA);
    rd(2'd2, rdv);
    check("full_push_pop_status", rdv, 32'h0000_0802);
    rd(2'd3, rdv);
    check("pop_1", rdv, 32'h0000_0001);
    for (int k = 2; k <= 9; k++) begin
      tick_n(256);
      rd(2'd3, rdv);
      check($sformatf("pop_%0d", k), rdv, (k <= 8) ? 32'(k) : 32'h0000_00AA);
      check($sformatf("pop_%0d_low", k), {31'b0, fifo_low}, {31'b0, (9 - k) <= 2});
    end
    rd(2'd2, rdv);
    check("drained_status", rdv, 32'h0000_0001);

    // reset mid-period with duty 0xFF, racing a DATA write
    do_reset();
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h0000_0001);
    wait_cur(8'hFF, 2000, n);
    tick_n(5);
    check("ff_pwm_high", {31'b0, pwm_out}, 32'h1);
    reset = 1'b1;
    we = 1'b1;
    sel = 2'd0;
    writeData = 32'h55;
    @(posedge clk);
    #1;
    reset = 1'b0;
    we = 1'b0;
    check("rst_pwm", {31'b0, pwm_out}, 32'h0);
    check("rst_low", {31'b0, fifo_low}, 32'h1);
    rd(2'd2, rdv);
    check("rst_status2", rdv, 32'h0000_0001);
    rd(2'd3, rdv);
    check("rst_cur2", rdv, 32'h0);
    rd(2'd1, rdv);
    check("rst_ctrl2", rdv, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
